// File: rtl/cdc_xfer_arbiter.sv
// cdc_xfer_arbiter: round-robin arbiter feeding a 4-phase req/ack CDC channel with ack resync and timeout
module cdc_xfer_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255,
  parameter int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                     clk_a,
  input  logic                     rst_a,
  input  logic [NUM_REQ-1:0]       src_valid,
  input  logic [NUM_REQ*DATA_W-1:0] src_data,
  output logic [NUM_REQ-1:0]       src_ready,
  output logic                     xfer_req,
  output logic [DATA_W-1:0]        xfer_data,
  output logic [ID_W-1:0]          xfer_src,
  input  logic                     xfer_ack_async,
  output logic                     busy,
  output logic                     timeout_err
);
  localparam int CNT_W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  typedef enum logic [1:0] {IDLE, REQ_HI, REQ_LO} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] sync;
  logic ack_s, found, grant;
  logic [ID_W-1:0] rr, win;
  logic [ID_W:0] idx;
  logic [CNT_W-1:0] cnt;
  assign ack_s = sync[SYNC_STAGES-1];
  always_comb begin
    win = '0;
    found = 1'b0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, rr} + (ID_W+1)'(k);
      idx = idx >= (ID_W+1)'(NUM_REQ) ? idx - (ID_W+1)'(NUM_REQ) : idx;
      if (src_valid[idx[ID_W-1:0]]) begin
        win = idx[ID_W-1:0];
        found = 1'b1;
      end
    end
  end
  // gating with rst_a keeps the combinational accept low while reset is held
  assign grant = (state == IDLE) && found && !ack_s && !rst_a;
  assign src_ready = grant ? NUM_REQ'(1) << win : '0;
  assign busy = state != IDLE;
  always_ff @(posedge clk_a or posedge rst_a)
    if (rst_a) sync <= '0;
    else sync <= {sync[SYNC_STAGES-2:0], xfer_ack_async};
  always_ff @(posedge clk_a or posedge rst_a) begin
    if (rst_a) begin
      state <= IDLE;
      rr <= '0;
      cnt <= '0;
      xfer_req <= 1'b0;
      xfer_data <= '0;
      xfer_src <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: if (grant) begin
          state <= REQ_HI;
          xfer_req <= 1'b1;
          xfer_data <= src_data[win*DATA_W +: DATA_W];
          xfer_src <= win;
          rr <= win == ID_W'(NUM_REQ - 1) ? '0 : win + 1'b1;
          cnt <= '0;
        end
        REQ_HI: if (ack_s) begin
          state <= REQ_LO;
          xfer_req <= 1'b0;
          cnt <= '0;
        end else if (TIMEOUT != 0 && cnt == TO_LAST) begin
          state <= REQ_LO;
          xfer_req <= 1'b0;
          timeout_err <= 1'b1;
          cnt <= '0;
        end else cnt <= cnt + 1'b1;
        REQ_LO: if (!ack_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cdc_xfer_arbiter.sv
// tb_cdc_xfer_arbiter: directed bench with grant scoreboard and an echoing receiver model
module tb_cdc_xfer_arbiter;
  localparam int N = 4, W = 8, S = 2, TO = 8;
  logic clk_a = 1'b0;
  logic rst_a = 1'b1;
  logic [N-1:0] src_valid = '0;
  logic [N*W-1:0] src_data = '0;
  logic [N-1:0] src_ready;
  logic xfer_req;
  logic [W-1:0] xfer_data;
  logic [1:0] xfer_src;
  logic xfer_ack_async;
  logic busy, timeout_err;
  logic echo_en = 1'b0, ack_echo = 1'b0, ack_force = 1'b0;
  int rcnt = 0;
  int errors = 0, checks = 0;
  typedef struct {int src; logic [W-1:0] data;} exp_t;
  exp_t sb[$];

  always #5 clk_a = ~clk_a;
  assign xfer_ack_async = echo_en ? ack_echo : ack_force;

  cdc_xfer_arbiter #(.NUM_REQ(N), .DATA_W(W), .SYNC_STAGES(S), .TIMEOUT(TO)) dut (
    .clk_a(clk_a), .rst_a(rst_a), .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready), .xfer_req(xfer_req), .xfer_data(xfer_data), .xfer_src(xfer_src),
    .xfer_ack_async(xfer_ack_async), .busy(busy), .timeout_err(timeout_err)
  );

  // receiver: ack follows req after three consecutive mismatching cycles
  always @(negedge clk_a) begin
    #2;
    if (!echo_en) rcnt = 0;
    else if (ack_echo != xfer_req) begin
      if (rcnt == 2) begin
        ack_echo = xfer_req;
        rcnt = 0;
      end else rcnt++;
    end else rcnt = 0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk_a);
    #1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] d);
    src_data[i*W +: W] = d;
    src_valid[i] = 1'b1;
  endtask

  task automatic expect_grant(input int i);
    sb.push_back('{i, src_data[i*W +: W]});
  endtask

  task automatic wait_grant(input string tag, input bit drop);
    exp_t e;
    int n = 0;
    #1;
    while (src_ready == '0 && n < 200) begin
      tick;
      n++;
    end
    chk({tag, "_seen"}, 32'(src_ready != '0), 1);
    e = sb.pop_front();
    chk({tag, "_ready"}, 32'(src_ready), 32'(1) << e.src);
    chk({tag, "_idle"}, {xfer_req, busy}, 0);
    tick;
    if (drop) src_valid[e.src] = 1'b0;
    chk({tag, "_one"}, 32'(src_ready), 0);
    chk({tag, "_req"}, 32'(xfer_req), 1);
    chk({tag, "_data"}, 32'(xfer_data), 32'(e.data));
    chk({tag, "_src"}, 32'(xfer_src), e.src);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 300) begin
      tick;
      n++;
    end
    chk({tag, "_idle"}, 32'(busy), 0);
  endtask

  task automatic wait_ack(input logic lvl, input string tag);
    int n = 0;
    while (xfer_ack_async !== lvl && n < 100) begin
      tick;
      n++;
    end
    chk(tag, 32'(xfer_ack_async), 32'(lvl));
  endtask

  initial begin
    int hi, pulses;
    src_valid = 4'b0001;
    tick;
    tick;
    chk("rst_ready", 32'(src_ready), 0);
    chk("rst_req", 32'(xfer_req), 0);
    chk("rst_data", 32'(xfer_data), 0);
    chk("rst_src", 32'(xfer_src), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_terr", 32'(timeout_err), 0);
    src_valid = '0;
    rst_a = 1'b0;
    tick;
    // single requester with echo
    echo_en = 1'b1;
    set_req(1, 8'hA5);
    expect_grant(1);
    wait_grant("single", 1);
    wait_ack(1'b1, "single_ackhi");
    chk("single_req_d1", 32'(xfer_req), 1);
    tick;
    chk("single_req_d2", 32'(xfer_req), 1);
    tick;
    chk("single_req_low", 32'(xfer_req), 0);
    chk("single_busy_lo", 32'(busy), 1);
    wait_ack(1'b0, "single_acklo");
    chk("single_busy_d1", 32'(busy), 1);
    tick;
    chk("single_busy_d2", 32'(busy), 1);
    tick;
    chk("single_busy_off", 32'(busy), 0);
    chk("single_hold", 32'(xfer_data), 32'h A5);
    // all four requesters continuously valid
    rst_a = 1'b1;
    tick;
    rst_a = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 8'(8'h10 + i));
    for (int k = 0; k < 6; k++) expect_grant(k % N);
    for (int k = 0; k < 6; k++) begin
      wait_grant("rr", 0);
      if (k < 5) wait_idle("rr");
    end
    src_valid = '0;
    wait_idle("rr_end");
    // pointer wrap after a grant to 3
    set_req(3, 8'h33);
    expect_grant(3);
    wait_grant("wrap3", 1);
    wait_idle("wrap3");
    set_req(0, 8'h20);
    set_req(2, 8'h22);
    expect_grant(0);
    expect_grant(2);
    wait_grant("wrap0", 1);
    wait_idle("wrap0");
    wait_grant("wrap2", 1);
    wait_idle("wrap2");
    // timeout with no ack
    echo_en = 1'b0;
    ack_force = 1'b0;
    set_req(1, 8'h5A);
    expect_grant(1);
    wait_grant("to", 1);
    set_req(2, 8'h77);
    hi = 1;
    pulses = 0;
    for (int k = 0; k < 20 && xfer_req; k++) begin
      tick;
      pulses += int'(timeout_err);
      if (xfer_req) hi++;
    end
    chk("to_hi_cycles", hi, TO);
    chk("to_err_edge", 32'(timeout_err), 1);
    echo_en = 1'b1;
    tick;
    chk("to_err_drop", 32'(timeout_err), 0);
    chk("to_pulses", pulses, 1);
    expect_grant(2);
    wait_grant("to_next", 1);
    wait_idle("to_next");
    // ack reaching the FSM on the last timeout cycle
    echo_en = 1'b0;
    set_req(3, 8'h3C);
    expect_grant(3);
    wait_grant("tie", 1);
    hi = 1;
    pulses = 0;
    for (int k = 0; k < 20 && xfer_req; k++) begin
      if (hi == 6) ack_force = 1'b1;
      tick;
      pulses += int'(timeout_err);
      if (xfer_req) hi++;
    end
    chk("tie_hi_cycles", hi, TO);
    ack_force = 1'b0;
    wait_idle("tie");
    chk("tie_pulses", pulses, 0);
    // reset during REQ_HI
    set_req(2, 8'h99);
    expect_grant(2);
    wait_grant("mid", 1);
    set_req(1, 8'h11);
    set_req(3, 8'h31);
    tick;
    #2 rst_a = 1'b1;
    #1;
    chk("mid_req", 32'(xfer_req), 0);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_ready", 32'(src_ready), 0);
    echo_en = 1'b1;
    tick;
    rst_a = 1'b0;
    expect_grant(1);
    expect_grant(3);
    wait_grant("mid_rr", 1);
    wait_idle("mid_rr");
    wait_grant("mid_next", 1);
    wait_idle("mid_next");
    // stale ack held in IDLE
    echo_en = 1'b0;
    ack_force = 1'b1;
    tick;
    tick;
    tick;
    set_req(2, 8'h42);
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("stale_hold", 32'(src_ready), 0);
    end
    ack_force = 1'b0;
    chk("stale_d0", 32'(src_ready), 0);
    tick;
    chk("stale_d1", 32'(src_ready), 0);
    tick;
    chk("stale_grant", 32'(src_ready), 32'b0100);
    echo_en = 1'b1;
    expect_grant(2);
    wait_grant("stale", 1);
    wait_idle("stale");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cdc_xfer_arbiter.md
Name: cdc_xfer_arbiter

Overview:
- Sender-side controller for a single clock-domain-crossing data channel shared by NUM_REQ local requesters.
- Grants requesters round-robin and latches the winner's word.
- Sequences a 4-phase req/ack handshake toward the receiving domain.
- The returning asynchronous ack is resynchronized internally through a SYNC_STAGES flop chain.
- Sits in the clk_a domain in front of the crossing; the receiving domain samples xfer_data once its synchronized xfer_req goes high.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_W, 8, payload width per requester
SYNC_STAGES, 2, ack synchronizer depth (>=2)
TIMEOUT, 255, max clk_a cycles in REQ_HI waiting for ack; 0 disables timeout
ID_W, $clog2(NUM_REQ), derived width of source index

Ports:
clk_a  input  1  sender-domain clock; all logic on posedge
rst_a  input  1  asynchronous, active-high reset
src_valid  input  NUM_REQ  requester i has a word pending; held until accepted
src_data  input  NUM_REQ*DATA_W  requester i word at bits [i*DATA_W +: DATA_W]
src_ready  output  NUM_REQ  one-hot, one-cycle accept pulse to granted requester
xfer_req  output  1  handshake request level toward receiving domain, driven from a flop
xfer_data  output  DATA_W  latched payload, stable whenever xfer_req=1
xfer_src  output  ID_W  index of requester owning xfer_data
xfer_ack_async  input  1  ack level from receiving domain, asynchronous to clk_a
busy  output  1  high in any state other than IDLE
timeout_err  output  1  one-cycle pulse when a transfer is abandoned by timeout

Behaviour:
- Reset (async, immediate): outputs src_ready=0, xfer_req=0, xfer_data=0, xfer_src=0, busy=0, timeout_err=0.
- Reset internal state: state=IDLE, rr pointer=0, sync chain all 0, timeout counter=0.
- ack_s = last stage of the SYNC_STAGES chain sampling xfer_ack_async. An ack edge is visible to the FSM SYNC_STAGES cycles after the clk_a edge that first captures it.
- Round-robin arbitration: search starts at rr pointer and wraps modulo NUM_REQ; the first i with src_valid[i]=1 wins. After a grant to i, rr = (i+1) mod NUM_REQ. rr is unchanged on cycles without a grant.
- IDLE, grant condition: any src_valid and ack_s=0.
- IDLE, on grant in cycle t:
  - src_ready[winner]=1 during cycle t (combinational from arbitration; requester sees accept at edge t).
  - At edge t, load xfer_data = winner's word and xfer_src = winner.
  - Go to REQ_HI; xfer_req=1 from cycle t+1.
- IDLE with ack_s=1 (stale ack): no grant; stay IDLE.
- REQ_HI: xfer_req=1; counter increments each cycle.
  - ack_s=1 -> REQ_LO, counter cleared.
  - Otherwise, if TIMEOUT!=0 and counter reaches TIMEOUT-1 -> REQ_LO, timeout_err pulses on the transition cycle, counter cleared.
  - ack_s=1 and timeout in the same cycle: ack wins; no timeout_err.
- REQ_LO: xfer_req=0; wait for ack_s=0, then -> IDLE.
  - A new grant is possible in the same cycle ack_s=0 is first seen in IDLE; i.e. next grant is no earlier than the cycle after the REQ_LO exit.
  - No timeout in REQ_LO.
- xfer_data and xfer_src change only at a grant edge; they hold their value after a transfer completes.
- Handshake rules:
  - Only one transfer is outstanding.
  - src_valid deasserting without an accept is tolerated (requester withdraws); it is simply not granted.
  - Minimum transfer cycle with an immediate receiver echo = 1 + 2*(SYNC_STAGES + receiver latency).
- Reset mid-transfer: xfer_req drops immediately; the receiving side is responsible for its own reset; rr returns to 0.

Test Plan:
- Single requester: src_valid[1]=1 data 0xA5; receiver echoes req->ack after 3 clk_a cycles.
  - Required: src_ready=4'b0010 for one cycle; xfer_req high next cycle with xfer_data=0xA5, xfer_src=1; req low 2 cycles after ack rises; busy low 2 cycles after ack falls.
- All four src_valid held continuously with distinct data 0x10..0x13, echo receiver.
  - Required: grant order 0,1,2,3,0,1; each src_ready is exactly one cycle; no two transfers overlap.
- rr wrap: after a grant to 3, only src_valid[0] and src_valid[2] high.
  - Required: 0 is granted first, then 2.
- Timeout, TIMEOUT=8, ack never asserted:
  - Required: xfer_req high exactly 8 cycles; timeout_err single pulse; FSM returns to IDLE; next pending request is granted.
- Ack arrives on the same cycle as timeout expiry:
  - Required: no timeout_err; normal completion.
- Assert rst_a asynchronously mid-REQ_HI.
  - Required: xfer_req, busy, src_ready = 0 before the next clk_a edge; after release, grant resumes from requester 0.
- Stale ack: hold xfer_ack_async=1 in IDLE with src_valid[2]=1.
  - Required: no grant until SYNC_STAGES cycles after ack falls.
